alarm_registers: RTL and testbench

//  Holds the user-set alarm time (hours, minutes) for the digital clock.

---
 rtl/alarm_registers.sv | 46 ++++
 tb/tb_alarm_registers.sv | 123 ++++++++++++
 2 files changed

// File: rtl/alarm_registers.sv
// Alarm time storage for the digital clock: independent hour and minute
// modulo counters advanced by level-sampled enables from the UI controller.
module alarm_registers #(
    parameter int unsigned HOURS_MAX   = 23,
    parameter int unsigned MINUTES_MAX = 59
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       inc_alarm_hours_en,
    input  logic       inc_alarm_minutes_en,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes
);

    localparam logic [4:0] HOURS_LAST   = 5'(HOURS_MAX);
    localparam logic [5:0] MINUTES_LAST = 6'(MINUTES_MAX);

    logic [4:0] hours_p0;
    logic [5:0] minutes_p0;

    // Using >= rather than == makes any out-of-range value fall back to 0
    function automatic logic [4:0] wrap_hours(input logic [4:0] h);
        return (h >= HOURS_LAST) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [5:0] wrap_minutes(input logic [5:0] m);
        return (m >= MINUTES_LAST) ? 6'd0 : m + 6'd1;
    endfunction

    // Fields are deliberately independent: a minute wrap never carries into hours
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            hours_p0   <= 5'd0;
            minutes_p0 <= 6'd0;
        end else begin
            if (inc_alarm_hours_en)
                hours_p0 <= wrap_hours(hours_p0);
            if (inc_alarm_minutes_en)
                minutes_p0 <= wrap_minutes(minutes_p0);
        end
    end

    assign alarm_hours   = hours_p0;
    assign alarm_minutes = minutes_p0;

endmodule

// File: tb/tb_alarm_registers.sv
// Directed bench for alarm_registers: a scoreboard queue holds expected
// hour:minute values pushed at drive time and popped after each sampling edge.
module tb_alarm_registers;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inc_alarm_hours_en = 1'b0;
    logic       inc_alarm_minutes_en = 1'b0;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;

    int n_tests = 0;
    int n_fail  = 0;
    int mh = 0;
    int mm = 0;
    logic [10:0] sb[$];

    alarm_registers dut (
        .sys_clk              (sys_clk),
        .rst_n                (rst_n),
        .inc_alarm_hours_en   (inc_alarm_hours_en),
        .inc_alarm_minutes_en (inc_alarm_minutes_en),
        .alarm_hours          (alarm_hours),
        .alarm_minutes        (alarm_minutes)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic compare(input string tag);
        logic [10:0] exp;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %0d:%0d", tag, alarm_hours, alarm_minutes);
            return;
        end
        exp = sb.pop_front();
        assert ({alarm_hours, alarm_minutes} === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d:%0d, expected %0d:%0d",
                   tag, alarm_hours, alarm_minutes, exp[10:6], exp[5:0]);
        end
    endtask

    task automatic push_model();
        sb.push_back({5'(mh), 6'(mm)});
    endtask

    task automatic expect_now(input string tag);
        push_model();
        compare(tag);
    endtask

    // Enables held high for n consecutive rising edges, checked after each one
    task automatic pulse(input logic h, input logic m, input int n, input string tag);
        @(negedge sys_clk);
        inc_alarm_hours_en   = h;
        inc_alarm_minutes_en = m;
        for (int i = 0; i < n; i++) begin
            if (h) mh = (mh + 1) % 24;
            if (m) mm = (mm + 1) % 60;
            push_model();
            @(posedge sys_clk);
            #1;
            compare(tag);
        end
        inc_alarm_hours_en   = 1'b0;
        inc_alarm_minutes_en = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        @(negedge sys_clk);
        #2 rst_n = 1'b0;
        mh = 0;
        mm = 0;
        #1 expect_now(tag);
        @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held for 100 ns, checked with and without edges passing
        #50 expect_now("reset_hold");
        @(posedge sys_clk);
        #1 expect_now("reset_hold_edge");
        #(100 - $time) rst_n = 1'b1;
        #1 expect_now("reset_release");

        pulse(1'b0, 1'b1, 1, "pre_reset_min");
        pulse(1'b1, 1'b0, 1, "pre_reset_hr");
        async_reset("reset_midcount");

        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 1, "min_step");
        for (int i = 0; i < 2; i++) pulse(1'b1, 1'b0, 1, "hr_step");

        for (int i = 0; i < 50; i++) pulse(1'b0, 1'b1, 1, "min_to_53");
        for (int i = 0; i < 6; i++)  pulse(1'b0, 1'b1, 1, "min_to_59");
        pulse(1'b0, 1'b1, 1, "min_wrap_no_carry");

        for (int i = 0; i < 20; i++) pulse(1'b1, 1'b0, 1, "hr_to_22");
        pulse(1'b1, 1'b0, 1, "hr_to_23");
        pulse(1'b1, 1'b0, 1, "hr_wrap");

        pulse(1'b1, 1'b0, 23, "hr_up_23");
        pulse(1'b0, 1'b1, 59, "min_up_59");
        pulse(1'b1, 1'b1, 1, "both_wrap");
        pulse(1'b1, 1'b0, 5, "hr_up_5");
        pulse(1'b0, 1'b1, 10, "min_up_10");
        pulse(1'b1, 1'b1, 1, "both_inc");

        async_reset("reset_before_hold");
        pulse(1'b0, 1'b1, 4, "min_held");
        for (int i = 0; i < 100; i++) begin
            @(posedge sys_clk);
            #1;
            if (i % 10 == 9) expect_now("idle_stable");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
